sram_responder: RTL
===================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 14: number of word-index bits; the memory holds 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h1C000000: byte base of the decoded window, aligned to 2^(ADDR_WIDTH+2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 inst_sram_en  input  1  request valid this cycle.
REQ-006 inst_sram_wen  input  4  byte-lane write enables; 4'b0000 means read.
REQ-007 inst_sram_addr  input  32  byte address.
REQ-008 inst_sram_wdata  input  32  write data, lane i = bits [8i+7:8i].
REQ-009 inst_sram_rdata  output  32  read data, registered.
REQ-010 addr_err  output  1  one-cycle pulse for an out-of-window request.
REQ-011 read_cnt  output  32  count of accepted in-window reads.
REQ-012 par_inject  input  1  on a write, store inverted parity for every written lane.
REQ-013 par_err  output  1  sticky parity-error flag.

Function
REQ-014 Request is in-window iff inst_sram_addr[31:ADDR_WIDTH+2] equals BASE_ADDR[31:ADDR_WIDTH+2]; word index = inst_sram_addr[ADDR_WIDTH+1:2]; addr[1:0] ignored.
REQ-015 Read = en=1 and wen=0. An in-window read at edge N drives the stored word on inst_sram_rdata from edge N until the next read updates it; latency is exactly one cycle.
REQ-016 inst_sram_rdata SHALL hold its value in every cycle without a read, including write cycles and en=0 cycles, so the fetch side can stall indefinitely.
REQ-017 Write = en=1 and wen!=0; only lanes with wen[i]=1 are updated at the edge; the other lanes are unchanged.
REQ-018 A read issued one cycle after a write to the same word returns the newly written bytes; there is no read/write collision in one cycle because each request is either a read or a write.
REQ-019 Out-of-window request: no memory update; a read loads 32'h0 into inst_sram_rdata; addr_err is 1 in the following cycle only.
REQ-020 en=0: no memory access, inst_sram_rdata unchanged, addr_err 0, read_cnt unchanged; wen/addr/wdata are don't-care.
REQ-021 read_cnt increments by 1 per in-window read, wraps from 32'hFFFFFFFF to 0, and excludes writes and out-of-window reads.
REQ-022 Back-to-back reads on consecutive cycles SHALL each return their own word one cycle later, with no bubble.

Reset
REQ-023 While reset=1 at an edge: inst_sram_rdata=0, addr_err=0, read_cnt=0, par_err=0; requests in that cycle are discarded.
REQ-024 Memory contents are not cleared by reset.
REQ-025 A request in the cycle after reset deassertion is serviced normally.

Configuration
REQ-026 Macro SRAM_PARITY_EN defined: one even-parity bit is stored per byte lane on every written lane (inverted when par_inject=1).
REQ-027 With SRAM_PARITY_EN defined: an in-window read whose data mismatches its stored parity on any lane sets par_err from the next edge until reset; read data is returned unmodified.
REQ-028 Macro SRAM_PARITY_EN undefined: no parity storage, par_inject ignored, par_err tied to 0.

Verification
REQ-029 Reset, write 32'hDEADBEEF with wen=4'hF at addr 32'h1C000010, then read it -> rdata=32'hDEADBEEF one cycle after the read, read_cnt=1.
REQ-030 With 32'hDEADBEEF stored at 32'h1C000010, write wen=4'b0010, wdata=32'h00005500, then read -> rdata=32'hDEAD55EF.
REQ-031 Read addr 32'h1C000010, then hold en=0 for 5 cycles -> rdata stays 32'hDEADBEEF (or the current stored word) on every stall cycle.
REQ-032 Read addr 32'h00000000 -> rdata=0, addr_err=1 for exactly one cycle, read_cnt unchanged.
REQ-033 Reads of 32'h1C000000, 32'h1C000004, 32'h1C000008 on consecutive cycles, holding 1, 2 and 3 -> rdata sequence 1, 2, 3 with no gaps.
REQ-034 SRAM_PARITY_EN defined: write 32'h12345678 with par_inject=1, then read it -> par_err=1 one cycle after the read and stays 1 until reset.

Source files
------------

// File: rtl/sram_responder.sv
// Single-port word SRAM behind a fixed address window; reads return registered data one cycle later and hold while idle.
// Optional per-lane parity under `SRAM_PARITY_EN; accepts a request every cycle, no backpressure.
module sram_responder #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h1C000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        addr_err,
  output logic [31:0] read_cnt,
  input  logic        par_inject,
  output logic        par_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_win;
  logic                  rd;
  logic                  wr;

  assign idx    = inst_sram_addr[ADDR_WIDTH+1:2];
  assign in_win = inst_sram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
  assign rd     = inst_sram_en && (inst_sram_wen == 4'b0000);
  assign wr     = inst_sram_en && (inst_sram_wen != 4'b0000);

  // Memory array is never reset; only writes outside reset touch it.
  always_ff @(posedge clk) begin
    if (!reset && wr && in_win) begin
      for (int i = 0; i < 4; i++) begin
        if (inst_sram_wen[i]) mem[idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_sram_rdata <= 32'h0;
      addr_err        <= 1'b0;
      read_cnt        <= 32'h0;
    end else begin
      addr_err <= inst_sram_en && !in_win;
      if (rd) begin
        if (in_win) begin
          inst_sram_rdata <= mem[idx];
          read_cnt        <= read_cnt + 32'd1;
        end else begin
          inst_sram_rdata <= 32'h0;
        end
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] lane_bad;

  always_ff @(posedge clk) begin
    if (!reset && wr && in_win) begin
      for (int i = 0; i < 4; i++) begin
        if (inst_sram_wen[i]) par_mem[idx][i] <= (^inst_sram_wdata[8*i +: 8]) ^ par_inject;
      end
    end
  end

  always_comb begin
    lane_bad = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      lane_bad[i] = (^mem[idx][8*i +: 8]) != par_mem[idx][i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      par_err <= 1'b0;
    end else if (rd && in_win && (lane_bad != 4'b0000)) begin
      par_err <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{par_inject, inst_sram_addr[1:0]};

endmodule
